m6502_bus_if: RTL

Parametrised bus interface unit between the m6502 core and the external system bus. It replaces fixed single-cycle bus strobing with a registered access sequencer that has per-region programmable wait states, external ready extension, and a bus timeout. It also synchronises the asynchronous interrupt and set-overflow inputs and converts NMI into an edge-latched request. It sits directly below the core wrapper and drives all external bus pins.

---
 rtl/m6502_bus_if.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/m6502_bus_if.sv
// m6502_bus_if: bus interface unit between the m6502 core and the external system bus.
//
// A registered access sequencer gives each address region its own programmable wait-state
// count, then lets the external bus_rdy stretch the access further, with an optional timeout
// that completes the access with an error. All bus strobes and core handshake outputs are
// registered. The asynchronous irq_n/nmi_n/sob_n inputs are synchronised, and NMI becomes an
// edge-latched request.
//
// Ports:
//   clk, res_n                 clock, asynchronous active-low reset
//   core_req/we_n/addr/wdata/vpa  access request from the core (held until core_ack)
//   core_ack/err/rdata/busy    completion pulse, timeout flag, read data, access in progress
//   cfg_wait                   per-region wait counts, region r at [r*WAIT_W +: WAIT_W]
//   bus_addr/wdata/den/we_n/oe_n/vpab  external bus pins
//   bus_datai, bus_rdy         external read data and ready
//   irq_n, nmi_n, sob_n        asynchronous interrupt / set-overflow inputs
//   irq_sync_n, sob_sync_n     synchronised levels
//   nmi_pend, nmi_ack          latched NMI request and its clear
module m6502_bus_if #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned REGION_BITS = 2,
   parameter int unsigned WAIT_W      = 3,
   parameter int unsigned TIMEOUT     = 255,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                                  clk,
   input  logic                                  res_n,
   input  logic                                  core_req,
   input  logic                                  core_we_n,
   input  logic [ADDR_W-1:0]                     core_addr,
   input  logic [DATA_W-1:0]                     core_wdata,
   input  logic                                  core_vpa,
   output logic                                  core_ack,
   output logic                                  core_err,
   output logic [DATA_W-1:0]                     core_rdata,
   output logic                                  core_busy,
   input  logic [WAIT_W*(1<<REGION_BITS)-1:0]    cfg_wait,
   output logic [ADDR_W-1:0]                     bus_addr,
   output logic [DATA_W-1:0]                     bus_wdata,
   output logic                                  bus_den,
   output logic                                  bus_we_n,
   output logic                                  bus_oe_n,
   output logic                                  bus_vpab,
   input  logic [DATA_W-1:0]                     bus_datai,
   input  logic                                  bus_rdy,
   input  logic                                  irq_n,
   input  logic                                  nmi_n,
   input  logic                                  sob_n,
   output logic                                  irq_sync_n,
   output logic                                  sob_sync_n,
   output logic                                  nmi_pend,
   input  logic                                  nmi_ack
);

   localparam int unsigned NumRegions = 1 << REGION_BITS;
   localparam int unsigned TcntW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StExt} state_e;

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
   logic [TcntW-1:0]    tcnt_q, tcnt_d;
   logic                lat_we_n_q, lat_we_n_d;
   logic                lat_vpa_q, lat_vpa_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                ack_q, ack_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                busy_q, busy_d;
   logic                den_q, den_d;
   logic                we_n_q, we_n_d;
   logic                oe_n_q, oe_n_d;
   logic                vpab_q, vpab_d;

   logic [REGION_BITS-1:0] region;
   logic [WAIT_W-1:0]      wait_sel;
   logic                   complete;
   logic                   timed_out;

   assign region = core_addr[ADDR_W-1 -: REGION_BITS];

   always_comb begin
      wait_sel = '0;
      for (int r = 0; r < NumRegions; r++) begin
         if (region == REGION_BITS'(r)) wait_sel = cfg_wait[r*WAIT_W +: WAIT_W];
      end
   end

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      tcnt_d     = tcnt_q;
      lat_we_n_d = lat_we_n_q;
      lat_vpa_d  = lat_vpa_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      rdata_d    = rdata_q;
      complete   = 1'b0;
      timed_out  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (core_req) begin
               addr_d     = core_addr;
               wdata_d    = core_wdata;
               lat_we_n_d = core_we_n;
               lat_vpa_d  = core_vpa;
               wcnt_d     = wait_sel;
               tcnt_d     = '0;
               state_d    = (wait_sel != '0) ? StWait : StExt;
            end
         end
         StWait: begin
            wcnt_d = wcnt_q - WAIT_W'(1);
            if (wcnt_q == WAIT_W'(1)) begin
               state_d = StExt;
               tcnt_d  = '0;
            end
         end
         StExt: begin
            if (bus_rdy) begin
               complete = 1'b1;
            end else if ((TIMEOUT != 0) && (tcnt_q == TcntW'(TIMEOUT))) begin
               // Ready has been low for TIMEOUT cycles already; this is one too many.
               complete  = 1'b1;
               timed_out = 1'b1;
            end else begin
               tcnt_d = tcnt_q + TcntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      if (complete) begin
         state_d = StIdle;
         ack_d   = 1'b1;
         err_d   = timed_out;
         if (lat_we_n_q) rdata_d = timed_out ? '1 : bus_datai;
      end

      // Strobes are registered from the next state so they change on the same edge as it.
      busy_d = (state_d != StIdle);
      if (busy_d) begin
         we_n_d = lat_we_n_d;
         oe_n_d = ~lat_we_n_d;
         den_d  = ~lat_we_n_d;
         vpab_d = ~lat_vpa_d;
      end else begin
         we_n_d = 1'b1;
         oe_n_d = 1'b1;
         den_d  = 1'b0;
         vpab_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q    <= StIdle;
         wcnt_q     <= '0;
         tcnt_q     <= '0;
         lat_we_n_q <= 1'b1;
         lat_vpa_q  <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         busy_q     <= 1'b0;
         den_q      <= 1'b0;
         we_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         vpab_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         tcnt_q     <= tcnt_d;
         lat_we_n_q <= lat_we_n_d;
         lat_vpa_q  <= lat_vpa_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         busy_q     <= busy_d;
         den_q      <= den_d;
         we_n_q     <= we_n_d;
         oe_n_q     <= oe_n_d;
         vpab_q     <= vpab_d;
      end
   end

   assign core_ack   = ack_q;
   assign core_err   = err_q;
   assign core_rdata = rdata_q;
   assign core_busy  = busy_q;
   assign bus_addr   = addr_q;
   assign bus_wdata  = wdata_q;
   assign bus_den    = den_q;
   assign bus_we_n   = we_n_q;
   assign bus_oe_n   = oe_n_q;
   assign bus_vpab   = vpab_q;

   // Interrupt synchronisers; stage 0 samples the pin.
   logic [SYNC_STAGES-1:0] irq_sync_q, nmi_sync_q, sob_sync_q;
   logic                   nmi_last_q;
   logic                   nmi_pend_q, nmi_pend_d;
   logic                   nmi_fall;

   assign nmi_fall   = nmi_last_q & ~nmi_sync_q[SYNC_STAGES-1];
   // A new falling edge wins over a simultaneous acknowledge so no request is lost.
   assign nmi_pend_d = nmi_fall | (nmi_pend_q & ~nmi_ack);

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         irq_sync_q <= '1;
         nmi_sync_q <= '1;
         sob_sync_q <= '1;
         nmi_last_q <= 1'b1;
         nmi_pend_q <= 1'b0;
      end else begin
         irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], irq_n};
         nmi_sync_q <= {nmi_sync_q[SYNC_STAGES-2:0], nmi_n};
         sob_sync_q <= {sob_sync_q[SYNC_STAGES-2:0], sob_n};
         nmi_last_q <= nmi_sync_q[SYNC_STAGES-1];
         nmi_pend_q <= nmi_pend_d;
      end
   end

   assign irq_sync_n = irq_sync_q[SYNC_STAGES-1];
   assign sob_sync_n = sob_sync_q[SYNC_STAGES-1];
   assign nmi_pend   = nmi_pend_q;

endmodule
